io_input_conditioner: RTL and testbench

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

---
 rtl/io_pkg.sv | 19 +
 rtl/debounce_bit.sv | 77 +++++++
 rtl/io_input_conditioner.sv | 68 ++++++
 tb/tb_io_input_conditioner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and types for the IO input block: register offsets,
// default sizing and the per-bit debounce FSM state type.
package io_pkg;

  localparam logic [3:0] IO_LED_OFFSET      = 4'h0;
  localparam logic [3:0] IO_SW_OFFSET       = 4'h4;
  localparam logic [3:0] IO_PB_OFFSET       = 4'h8;
  localparam logic [3:0] IO_PB_PRESS_OFFSET = 4'hC;

  localparam int DEF_SW_WIDTH        = 16;
  localparam int DEF_PB_WIDTH        = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: two-flop synchronizer, then a counter/FSM that only
// accepts a new level after DEBOUNCE_CYCLES consecutive mismatching cycles.
module debounce_bit
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic update
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt, cnt_nxt;
  db_state_t     state, state_nxt;
  logic          mismatch;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], raw};
  end

  // The counter tracks mismatching cycles seen so far, so the IDLE->COUNT
  // transition already accounts for the first one by loading 1.
  always_comb begin
    mismatch  = sync_q[1] ^ stable;
    state_nxt = state;
    cnt_nxt   = cnt;
    update    = 1'b0;
    case (state)
      DB_IDLE: begin
        cnt_nxt = '0;
        if (mismatch) begin
          state_nxt = DB_COUNT;
          cnt_nxt   = CNT_ONE;
        end
      end
      DB_COUNT: begin
        if (!mismatch) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          update    = 1'b1;
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // FSM, counter and accepted level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DB_IDLE;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      stable <= stable ^ update;
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces slide switches and push buttons, and derives the switch-change
// pulse, button press pulses and sticky write-1-to-clear press flags.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int SW_WIDTH        = DEF_SW_WIDTH,
  parameter int PB_WIDTH        = DEF_PB_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw_in,
  input  logic [PB_WIDTH-1:0] pb_in,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic [PB_WIDTH-1:0] pb_stable,
  output logic [PB_WIDTH-1:0] pb_press,
  input  logic                pb_clr_we,
  input  logic [PB_WIDTH-1:0] pb_clr_mask,
  output logic                sw_change,
  output logic [PB_WIDTH-1:0] pb_press_pulse
);

  logic [SW_WIDTH-1:0] sw_upd;
  logic [PB_WIDTH-1:0] pb_upd;
  logic [PB_WIDTH-1:0] pb_rise;
  logic [PB_WIDTH-1:0] pb_clr;

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_in[i]),
      .stable (sw_stable[i]),
      .update (sw_upd[i])
    );
  end

  for (genvar i = 0; i < PB_WIDTH; i++) begin : g_pb
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (pb_in[i]),
      .stable (pb_stable[i]),
      .update (pb_upd[i])
    );
  end

  // Edges are taken from the debouncers' update strobes so the pulses and
  // flags land on the same edge as the stable level changes.
  always_comb begin
    pb_rise = pb_upd & ~pb_stable;
    pb_clr  = pb_clr_we ? pb_clr_mask : '0;
  end

  // Change/press pulses and sticky press flags; a set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_change      <= 1'b0;
      pb_press_pulse <= '0;
      pb_press       <= '0;
    end else begin
      sw_change      <= |sw_upd;
      pb_press_pulse <= pb_rise;
      pb_press       <= (pb_press & ~pb_clr) | pb_rise;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_io_input_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_in;
  logic [3:0]  pb_in;
  logic [15:0] sw_stable;
  logic [3:0]  pb_stable;
  logic [3:0]  pb_press;
  logic        pb_clr_we;
  logic [3:0]  pb_clr_mask;
  logic        sw_change;
  logic [3:0]  pb_press_pulse;

  int total = 0;
  int bad   = 0;

  io_input_conditioner #(
    .SW_WIDTH        (16),
    .PB_WIDTH        (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sw_in          (sw_in),
    .pb_in          (pb_in),
    .sw_stable      (sw_stable),
    .pb_stable      (pb_stable),
    .pb_press       (pb_press),
    .pb_clr_we      (pb_clr_we),
    .pb_clr_mask    (pb_clr_mask),
    .sw_change      (sw_change),
    .pb_press_pulse (pb_press_pulse)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle at the falling edge to sample and drive.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_in = '0; pb_in = '0; pb_clr_we = 1'b0; pb_clr_mask = '0;
    cyc(); cyc();
    total++;
    if ({sw_stable, pb_stable, pb_press, sw_change, pb_press_pulse} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got sw=%h pb=%h press=%h chg=%b pulse=%h want all 0",
               sw_stable, pb_stable, pb_press, sw_change, pb_press_pulse);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_step();
    int changes = 0;
    sw_in = 16'h0005;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      if (sw_change) changes++;
      if (k == 5) begin
        total++;
        if (sw_stable !== 16'h0000) begin
          bad++; $display("FAIL step_early: got %h want 0000", sw_stable);
        end
      end
      if (k == 6) begin
        total++;
        if (sw_stable !== 16'h0005 || sw_change !== 1'b1) begin
          bad++; $display("FAIL step_edge6: got sw=%h chg=%b want 0005/1", sw_stable, sw_change);
        end
      end
    end
    total++;
    if (changes != 1 || sw_change !== 1'b0) begin
      bad++; $display("FAIL step_change_pulse: got count=%0d chg=%b want 1/0", changes, sw_change);
    end
  endtask

  task automatic test_glitch();
    int seen = 0;
    pb_in = 4'h1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) pb_in = 4'h0;
      cyc();
      if (pb_stable !== 4'h0 || pb_press !== 4'h0 || pb_press_pulse !== 4'h0) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL glitch_reject: got %0d nonzero cycles want 0", seen);
    end
  endtask

  task automatic test_press_clear();
    pb_in = 4'h2;
    repeat (6) cyc();
    total++;
    if (pb_stable !== 4'h2 || pb_press_pulse !== 4'h2 || pb_press !== 4'h2) begin
      bad++; $display("FAIL press_set: got st=%h pulse=%h press=%h want 2/2/2",
                      pb_stable, pb_press_pulse, pb_press);
    end
    cyc();
    total++;
    if (pb_press_pulse !== 4'h0 || pb_press !== 4'h2) begin
      bad++; $display("FAIL press_pulse_end: got pulse=%h press=%h want 0/2", pb_press_pulse, pb_press);
    end
    pb_in = 4'h0;
    repeat (6) cyc();
    total++;
    if (pb_stable !== 4'h0 || pb_press !== 4'h2 || pb_press_pulse !== 4'h0) begin
      bad++; $display("FAIL release_keeps_press: got st=%h press=%h pulse=%h want 0/2/0",
                      pb_stable, pb_press, pb_press_pulse);
    end
    pb_clr_mask = 4'h2; pb_clr_we = 1'b0;
    cyc();
    total++;
    if (pb_press !== 4'h2) begin
      bad++; $display("FAIL mask_without_we: got %h want 2", pb_press);
    end
    pb_clr_we = 1'b1;
    cyc();
    pb_clr_we = 1'b0; pb_clr_mask = 4'h0;
    total++;
    if (pb_press !== 4'h0) begin
      bad++; $display("FAIL press_clear: got %h want 0", pb_press);
    end
  endtask

  task automatic test_collision();
    pb_in = 4'h1;
    repeat (5) cyc();
    pb_clr_we = 1'b1; pb_clr_mask = 4'h1;
    cyc();
    pb_clr_we = 1'b0; pb_clr_mask = 4'h0;
    total++;
    if (pb_stable !== 4'h1 || pb_press !== 4'h1 || pb_press_pulse !== 4'h1) begin
      bad++; $display("FAIL set_beats_clear: got st=%h press=%h pulse=%h want 1/1/1",
                      pb_stable, pb_press, pb_press_pulse);
    end
    pb_clr_we = 1'b1; pb_clr_mask = 4'h1; pb_in = 4'h0;
    cyc();
    pb_clr_we = 1'b0; pb_clr_mask = 4'h0;
    repeat (7) cyc();
    total++;
    if (pb_press !== 4'h0 || pb_stable !== 4'h0) begin
      bad++; $display("FAIL collision_cleanup: got press=%h st=%h want 0/0", pb_press, pb_stable);
    end
  endtask

  task automatic test_bounce();
    int changes = 0;
    int wrong = 0;
    for (int i = 0; i < 20; i++) begin
      sw_in = 16'h0005 | (((i / 2) % 2 == 0) ? 16'h0008 : 16'h0000);
      cyc();
      if (sw_change) changes++;
      if (sw_stable !== 16'h0005) wrong++;
    end
    sw_in = 16'h000D;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (sw_change) changes++;
      if (k < 6 && sw_stable !== 16'h0005) wrong++;
    end
    total++;
    if (sw_stable !== 16'h000D || wrong != 0) begin
      bad++; $display("FAIL bounce_settle: got sw=%h early_wrong=%0d want 000d/0", sw_stable, wrong);
    end
    repeat (4) begin
      cyc();
      if (sw_change) changes++;
    end
    total++;
    if (changes != 1) begin
      bad++; $display("FAIL bounce_single_change: got %0d pulses want 1", changes);
    end
  endtask

  task automatic test_reset_midcount();
    int wrong = 0;
    sw_in = 16'h0001;
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    total++;
    if ({sw_stable, pb_stable, pb_press, sw_change, pb_press_pulse} !== '0) begin
      bad++; $display("FAIL midcount_reset_outputs: got sw=%h chg=%b want 0000/0", sw_stable, sw_change);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k < 6 && (sw_stable !== 16'h0000 || sw_change !== 1'b0)) wrong++;
    end
    total++;
    if (sw_stable !== 16'h0001 || sw_change !== 1'b1 || wrong != 0) begin
      bad++; $display("FAIL midcount_restart: got sw=%h chg=%b early_wrong=%0d want 0001/1/0",
                      sw_stable, sw_change, wrong);
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_glitch();
    test_press_clear();
    test_collision();
    test_bounce();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
